// File: rtl/instr_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_enc_pkg                                                   |
// | Brief    : Shared constants, types and helpers for the RV32I encoder.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package instr_enc_pkg;

    localparam logic [2:0] c_fmt_r = 3'd0;
    localparam logic [2:0] c_fmt_i = 3'd1;
    localparam logic [2:0] c_fmt_s = 3'd2;
    localparam logic [2:0] c_fmt_b = 3'd3;
    localparam logic [2:0] c_fmt_u = 3'd4;
    localparam logic [2:0] c_fmt_j = 3'd5;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [31:0] c_nop_word = 32'h0000_0013;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_desc_t;

    // True when v equals the sign extension of v[top:0].
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned top);
        logic [31:0] s;
        s = v << (31 - top);
        s = $signed(s) >>> (31 - top);
        return s == v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_encoder_if                                                |
// | Brief    : Control, descriptor and memory-write bundle of the encoder.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface instr_encoder_if
    import instr_enc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   start;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [COUNT_WIDTH-1:0] count;
    logic                   busy;
    logic                   done;
    logic                   err;

    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_fmt;
    logic [6:0]             in_opcode;
    logic [2:0]             in_funct3;
    logic [6:0]             in_funct7;
    logic [4:0]             in_rd;
    logic [4:0]             in_rs1;
    logic [4:0]             in_rs2;
    logic [31:0]            in_imm;

    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [31:0]            mem_wdata;

    modport master (
        output start, base_addr, count,
        output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
        output in_rd, in_rs1, in_rs2, in_imm,
        output mem_ready,
        input  busy, done, err, in_ready, mem_valid, mem_addr, mem_wdata
    );

    modport slave (
        input  start, base_addr, count,
        input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
        input  in_rd, in_rs1, in_rs2, in_imm,
        input  mem_ready,
        output busy, done, err, in_ready, mem_valid, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_pack                                                      |
// | Brief    : Combinational descriptor-to-RV32I word packer with range check. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instr_pack
    import instr_enc_pkg::*;
(
    input  instr_desc_t i_desc,
    output logic [31:0] o_word,
    output logic        o_range_err
);

    logic [31:0] w_imm;
    assign w_imm = i_desc.imm;

    // Out-of-range immediates still produce a word built from the truncated fields.
    always_comb begin
        o_word      = c_nop_word;
        o_range_err = 1'b0;
        case (i_desc.fmt)
            c_fmt_r: begin
                o_word = {i_desc.funct7, i_desc.rs2, i_desc.rs1, i_desc.funct3,
                          i_desc.rd, i_desc.opcode};
            end
            c_fmt_i: begin
                o_word      = {w_imm[11:0], i_desc.rs1, i_desc.funct3, i_desc.rd, i_desc.opcode};
                o_range_err = !fits_signed(w_imm, 11);
            end
            c_fmt_s: begin
                o_word      = {w_imm[11:5], i_desc.rs2, i_desc.rs1, i_desc.funct3,
                               w_imm[4:0], i_desc.opcode};
                o_range_err = !fits_signed(w_imm, 11);
            end
            c_fmt_b: begin
                o_word      = {w_imm[12], w_imm[10:5], i_desc.rs2, i_desc.rs1, i_desc.funct3,
                               w_imm[4:1], w_imm[11], i_desc.opcode};
                o_range_err = !fits_signed(w_imm, 12) || w_imm[0];
            end
            c_fmt_u: begin
                o_word      = {w_imm[31:12], i_desc.rd, i_desc.opcode};
                o_range_err = (w_imm[11:0] != 12'd0);
            end
            c_fmt_j: begin
                o_word      = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                               i_desc.rd, i_desc.opcode};
                o_range_err = !fits_signed(w_imm, 20) || w_imm[0];
            end
            default: begin
                o_word      = c_nop_word;
                o_range_err = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_encoder                                                   |
// | Brief    : Packs instruction descriptors and streams them to imem writes.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    instr_encoder_if.slave bus
);

    logic [1:0]             r_state;
    logic [ADDR_WIDTH-1:0]  r_cur_addr;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_err;
    logic                   r_mem_valid;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [31:0]            r_mem_wdata;

    instr_desc_t            w_desc;
    logic [31:0]            w_word;
    logic                   w_pack_err;
    logic                   w_out_free;
    logic                   w_in_ready;
    logic                   w_accept;

    assign w_desc = '{fmt:    bus.in_fmt,
                      opcode: bus.in_opcode,
                      funct3: bus.in_funct3,
                      funct7: bus.in_funct7,
                      rd:     bus.in_rd,
                      rs1:    bus.in_rs1,
                      rs2:    bus.in_rs2,
                      imm:    bus.in_imm};

    instr_pack u_pack (
        .i_desc      (w_desc),
        .o_word      (w_word),
        .o_range_err (w_pack_err)
    );

    // The output register can take a new word when empty or draining this cycle.
    assign w_out_free = !r_mem_valid || bus.mem_ready;
    assign w_in_ready = (r_state == c_st_run) && (r_remaining != '0) && w_out_free;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_cur_addr  <= bus.base_addr;
                        r_remaining <= bus.count;
                        r_err       <= 1'b0;
                        r_state     <= (bus.count == '0) ? c_st_done : c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_accept) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= r_cur_addr;
                        r_mem_wdata <= w_word;
                        r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(4);
                        r_remaining <= r_remaining - COUNT_WIDTH'(1);
                        if (w_pack_err) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_out_free) begin
                        r_mem_valid <= 1'b0;
                    end
                    if ((r_remaining == '0) && w_out_free) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state == c_st_run) || (r_state == c_st_done);
    assign bus.done      = (r_state == c_st_done);
    assign bus.err       = r_err;
    assign bus.in_ready  = w_in_ready;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_encoder                                                |
// | Brief    : Directed + randomized bench with arithmetic reference encoder.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) bus ();

    instr_encoder #(.ADDR_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: field placement by shift/mask, ranges by signed compare.
    function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [31:0] imm);
        int          v;
        logic [31:0] w;
        logic [31:0] b;
        logic        e;
        v = imm;
        b = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
        e = 1'b0;
        case (f)
            3'd0: w = b | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
            3'd1: begin
                w = b | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
                e = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                w = b | (32'(rs2) << 20) | ((imm & 32'h1F) << 7) | (((imm >> 5) & 32'h7F) << 25);
                e = (v < -2048) || (v > 2047);
            end
            3'd3: begin
                w = b | (32'(rs2) << 20) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
                e = (v < -4096) || (v > 4095) || ((imm & 32'h1) != 0);
            end
            3'd4: begin
                w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFFF000);
                e = (imm & 32'hFFF) != 0;
            end
            3'd5: begin
                w = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                      | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
                e = (v < -1048576) || (v > 1048575) || ((imm & 32'h1) != 0);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic do_start(input logic [31:0] base, input logic [15:0] cnt);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.count     = cnt;
        tick();
        bus.start = 1'b0;
        exp_addr  = base;
        exp_err   = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_word, input logic exp_e);
        logic got;
        bus.in_fmt = f;     bus.in_opcode = op; bus.in_funct3 = f3; bus.in_funct7 = f7;
        bus.in_rd  = rd;    bus.in_rs1 = rs1;   bus.in_rs2 = rs2;   bus.in_imm = imm;
        bus.in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rnd_ready) bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                exp_addr_q.push_back(exp_addr);
                exp_word_q.push_back(exp_word);
                exp_addr = exp_addr + 32'd4;
                exp_err  = exp_err | exp_e;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        if (!got) chk("in_ready_timeout", 64'(got), 64'd1);
    endtask

    task automatic send_rand();
        logic [2:0]  f;
        logic [31:0] imm;
        logic [32:0] r;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        f  = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        op = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        case (f)
            3'd1, 3'd2: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            3'd3:       imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            3'd4:       imm = $urandom & 32'hFFFFF000;
            3'd5:       imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            default:    imm = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) imm = $urandom;
        r = ref_enc(f, op, 3'($urandom), 7'($urandom), rd, rs1, rs2, imm);
        // Recompute with the exact funct fields that get driven.
        begin
            logic [2:0] f3;
            logic [6:0] f7;
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            r  = ref_enc(f, op, f3, f7, rd, rs1, rs2, imm);
            send(f, op, f3, f7, rd, rs1, rs2, imm, r[31:0], r[32]);
        end
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 64'(got), 64'd1);
        chk({tag, "_all_written"}, 64'(exp_addr_q.size()), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'(exp_err));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
        tick();
    endtask

    // Write scoreboard and hold-while-stalled monitor.
    logic        stall_prev = 1'b0;
    logic [31:0] hold_a, hold_d;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(bus.mem_valid), 64'd1);
                chk("hold_addr", 64'(bus.mem_addr), 64'(hold_a));
                chk("hold_data", 64'(bus.mem_wdata), 64'(hold_d));
            end
            if (bus.mem_valid && bus.mem_ready) begin
                if (exp_word_q.size() == 0) begin
                    chk("unexpected_write", 64'(bus.mem_addr), 64'hDEAD_0000_0000);
                end else begin
                    chk("wr_addr", 64'(bus.mem_addr), 64'(exp_addr_q.pop_front()));
                    chk("wr_data", 64'(bus.mem_wdata), 64'(exp_word_q.pop_front()));
                end
            end
            stall_prev <= bus.mem_valid && !bus.mem_ready;
            hold_a     <= bus.mem_addr;
            hold_d     <= bus.mem_wdata;
        end
    end

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.count = '0;
        bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0; bus.in_funct3 = '0;
        bus.in_funct7 = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
        bus.mem_ready = 1'b1;
        exp_addr = '0; exp_err = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        rst = 1'b0;
        tick();

        // One instruction per format, fixed golden words.
        do_start(32'h100, 16'd6);
        send(c_fmt_r, c_opc_op,     3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,        32'h002081B3, 1'b0);
        send(c_fmt_i, c_opc_op_imm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send(c_fmt_s, c_opc_store,  3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0);
        send(c_fmt_b, c_opc_branch, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        send(c_fmt_u, c_opc_lui,    3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send(c_fmt_j, c_opc_jal,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0);
        @(negedge clk);
        chk("fmt_last_valid", 64'(bus.mem_valid), 64'd1);
        chk("fmt_done_early", 64'(bus.done), 64'd0);
        @(negedge clk);
        chk("fmt_done", 64'(bus.done), 64'd1);
        chk("fmt_done_no_valid", 64'(bus.mem_valid), 64'd0);
        chk("fmt_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        chk("fmt_done_pulse", 64'(bus.done), 64'd0);
        chk("fmt_idle", 64'(bus.busy), 64'd0);
        tick();

        // Memory backpressure mid-program.
        do_start(32'h180, 16'd4);
        send_rand();
        send_rand();
        bus.mem_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_valid", 64'(bus.mem_valid), 64'd1);
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        send_rand();
        send_rand();
        wait_done("bp");

        // Range error and invalid format.
        do_start(32'h200, 16'd2);
        send(c_fmt_b, c_opc_branch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h00000163, 1'b1);
        chk("err_b_sticky", 64'(bus.err), 64'd1);
        send(3'd7, 7'h7F, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h1234, 32'h00000013, 1'b1);
        wait_done("err");
        chk("err_held_idle", 64'(bus.err), 64'd1);

        // Empty program; its start also clears err.
        do_start(32'h400, 16'd0);
        chk("c0_err_cleared", 64'(bus.err), 64'd0);
        @(negedge clk);
        chk("c0_busy", 64'(bus.busy), 64'd1);
        chk("c0_done", 64'(bus.done), 64'd1);
        chk("c0_no_valid", 64'(bus.mem_valid), 64'd0);
        @(negedge clk);
        chk("c0_idle", 64'(bus.busy), 64'd0);
        chk("c0_done_pulse", 64'(bus.done), 64'd0);
        tick();

        // Address wrap.
        do_start(32'hFFFFFFFC, 16'd2);
        send_rand();
        send_rand();
        wait_done("wrap");

        // start while busy is ignored.
        do_start(32'h500, 16'd3);
        send_rand();
        bus.start = 1'b1; bus.base_addr = 32'h999; bus.count = 16'd0;
        tick();
        bus.start = 1'b0;
        chk("busy_start_ignored", 64'(bus.busy), 64'd1);
        send_rand();
        send_rand();
        wait_done("busy_start");

        // Reset with a word pending.
        do_start(32'h600, 16'd3);
        bus.mem_ready = 1'b0;
        send_rand();
        rst = 1'b1;
        tick();
        chk("rst_pend_valid", 64'(bus.mem_valid), 64'd0);
        chk("rst_pend_busy", 64'(bus.busy), 64'd0);
        chk("rst_pend_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_word_q.delete();
        bus.mem_ready = 1'b1;
        tick();

        // Randomized program with random memory backpressure.
        do_start(32'h700, 16'd24);
        rnd_ready = 1'b1;
        for (int n = 0; n < 24; n++) send_rand();
        rnd_ready = 1'b0;
        bus.mem_ready = 1'b1;
        wait_done("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
